ws2812b_driver: RTL and testbench
=================================

Name: ws2812b_driver

Overview:
- Downstream serialiser for the LED ring. Consumes the 12-bit lit-LED mask and 8-bit intensity from the rotary/push controller and drives a WS2812B chain on one output pin.
- Repeats frames continuously: reset gap, one input snapshot, then NUM_LEDS × 24 bit cells, GRB order, MSB first, LED 0 first.
- Runs on the 40 MHz system clock; all timing is in clock cycles.

Parameters:
- NUM_LEDS, 12, number of LEDs in the chain (width of led_mask).
- T_BIT, 50, bit-cell length in cycles (1.25 µs).
- T0H, 16, high time of a '0' bit in cycles (0.4 µs).
- T1H, 32, high time of a '1' bit in cycles (0.8 µs).
- T_RESET, 2400, low gap between frames in cycles (60 µs).
- CH_EN, 3'b111, channel enables {G,R,B}. A lit LED drives an enabled channel to intensity and a disabled channel to 0.

Ports:
- clk  in  1  system clock, 40 MHz.
- res  in  1  asynchronous, active-high reset.
- led_mask  in  NUM_LEDS  bit i=1: LED i lit.
- intensity  in  8  channel value applied to lit LEDs.
- enable  in  1  1: frames are allowed to start.
- dout  out  1  WS2812B data line, registered.
- busy  out  1  high while bit cells are being sent.
- frame_start  out  1  one-cycle pulse in the LOAD cycle.

Behaviour:
- Reset (res=1, async):
  - state=GAP, gap counter=0.
  - dout=0, busy=0, frame_start=0.
  - Snapshot registers cleared.
  - Reset mid-frame aborts the frame immediately; dout goes low at once.
- States: GAP -> LOAD -> SEND -> GAP.
- GAP:
  - dout=0, busy=0; counter counts 0..T_RESET-1, then saturates.
  - On the cycle the counter is at T_RESET-1 (or saturated) and enable=1, the next state is LOAD.
  - While enable=0 the block stays in GAP indefinitely with dout low.
- LOAD (exactly 1 cycle):
  - Snapshot led_mask and intensity; pulse frame_start=1; dout=0.
  - Build the 24-bit word per LED: {G,R,B}, each channel = (mask_i & CH_EN[ch]) ? intensity : 8'h00.
  - Input changes after LOAD have no effect on the frame in flight.
- SEND:
  - busy=1 from the first SEND cycle through the last.
  - Bit cells are T_BIT cycles, back to back, with no idle cycles between bits or between LEDs.
  - In each cell dout is high for exactly T0H ('0') or T1H ('1') consecutive cycles starting at cell cycle 0, then low for the remainder.
  - Bit order: LED 0 first, then LED 1, ... LED NUM_LEDS-1. Within each LED: G7..G0, R7..R0, B7..B0.
  - After the last cell of LED NUM_LEDS-1, the next state is GAP with counter=0. A SEND duration of NUM_LEDS*24*T_BIT cycles (14400 by default) is required.
- Timing:
  - Minimum frame period = T_RESET + 1 + NUM_LEDS*24*T_BIT = 16801 cycles.
  - First dout rise occurs T_RESET+1 cycles after res deasserts, given enable=1.
- enable deassertion during SEND does not truncate the frame; it only blocks the next LOAD.
- Counters:
  - Bit-cell counter width is ceil(log2(T_BIT)).
  - Bit index counts 0..23; LED index counts 0..NUM_LEDS-1.
  - Gap counter is wide enough for T_RESET. All wrap-around is explicit, never overflow.
- Elaboration checks: 0 < T0H < T1H < T_BIT, and NUM_LEDS ≥ 1.

Test Plan:
- Reset, enable=1, mask=12'h001, intensity=8'h20, CH_EN=111 -> dout low 2400 cycles; frame_start pulse at cycle 2400; first cell starts cycle 2401. Decoded LED0 = G20 R20 B20; LEDs 1–11 = 000000; busy high for exactly 14400 cycles.
- Pulse-width check on every cell -> '1' cells high exactly 32 cycles, '0' cells exactly 16; each cell is 50 cycles; no gaps between cells.
- mask=12'h800, intensity=8'h01, CH_EN=3'b010 -> LED11 = G00 R01 B00; all other LEDs zero; last 24 cells carry 0x000100.
- Change mask and intensity in the middle of SEND -> current frame unchanged; next frame (after the 2400-cycle gap) reflects the new values.
- enable=0 at reset, held 10000 cycles, then set to 1 -> dout stays low throughout; LOAD occurs on the cycle after enable rises; the frame is sent normally.
- Assert res in the middle of a '1' high phase -> dout=0 and busy=0 immediately; after release, a full 2400-cycle gap precedes the next frame.

Source files
------------

// File: rtl/ws2812b_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : ws2812b_driver_if
//  Purpose  : Bus between the rotary/push controller and the WS2812B
//             serialiser. The controller side drives the LED mask, intensity
//             and enable; the serialiser side drives the data line and status.
//  Signals  : led_mask    [NUM_LEDS] bit i=1 -> LED i lit
//             intensity   [8]        channel value applied to lit LEDs
//             enable      [1]        1: frames are allowed to start
//             dout        [1]        WS2812B data line (registered)
//             busy        [1]        high while bit cells are being sent
//             frame_start [1]        one-cycle pulse in the LOAD cycle
//  Revision : 1.0 - initial release
// ============================================================================
interface ws2812b_driver_if #(
    parameter int NUM_LEDS = 12
);
    logic [NUM_LEDS-1:0] led_mask;
    logic [7:0]          intensity;
    logic                enable;
    logic                dout;
    logic                busy;
    logic                frame_start;

    modport master (
        output led_mask,
        output intensity,
        output enable,
        input  dout,
        input  busy,
        input  frame_start
    );

    modport slave (
        input  led_mask,
        input  intensity,
        input  enable,
        output dout,
        output busy,
        output frame_start
    );
endinterface
`default_nettype wire

// File: rtl/ws2812b_driver.sv
`default_nettype none
// ============================================================================
//  Module   : ws2812b_driver
//  Purpose  : Continuous WS2812B frame generator. Each frame is a low reset
//             gap, a one-cycle input snapshot (LOAD), then NUM_LEDS x 24 bit
//             cells in GRB order, MSB first, LED 0 first.
//  Ports    : clk  - system clock (40 MHz)
//             res  - asynchronous active-high reset
//             bus  - ws2812b_driver_if.slave (led_mask, intensity, enable in;
//                    dout, busy, frame_start out)
//  Revision : 1.0 - initial release
// ============================================================================
module ws2812b_driver #(
    parameter int         NUM_LEDS = 12,
    parameter int         T_BIT    = 50,
    parameter int         T0H      = 16,
    parameter int         T1H      = 32,
    parameter int         T_RESET  = 2400,
    parameter logic [2:0] CH_EN    = 3'b111
) (
    input  wire logic       clk,
    input  wire logic       res,
    ws2812b_driver_if.slave bus
);

    localparam int CW = $clog2(T_BIT);
    localparam int GW = $clog2(T_RESET + 1);
    localparam int LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [1:0] c_ST_GAP  = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_SEND = 2'd2;

    localparam logic [CW-1:0] c_CELL_LAST = CW'(T_BIT - 1);
    localparam logic [CW-1:0] c_T0H_LAST  = CW'(T0H - 1);
    localparam logic [CW-1:0] c_T1H_LAST  = CW'(T1H - 1);
    localparam logic [GW-1:0] c_GAP_LAST  = GW'(T_RESET - 1);
    localparam logic [LW-1:0] c_LED_LAST  = LW'(NUM_LEDS - 1);
    localparam logic [4:0]    c_BIT_LAST  = 5'd23;

    generate
        if (!(T0H > 0 && T1H > T0H && T_BIT > T1H)) begin : g_chk_timing
            $error("ws2812b_driver: require 0 < T0H < T1H < T_BIT");
        end
        if (NUM_LEDS < 1) begin : g_chk_leds
            $error("ws2812b_driver: NUM_LEDS must be at least 1");
        end
        if (T_RESET < 1) begin : g_chk_gap
            $error("ws2812b_driver: T_RESET must be at least 1");
        end
    endgenerate

    logic [1:0]          r_state;
    logic [1:0]          w_state_nx;
    logic [GW-1:0]       r_gap_cnt;
    logic [CW-1:0]       r_cell_cnt;
    logic [4:0]          r_bit_idx;
    logic [LW-1:0]       r_led_idx;
    logic [NUM_LEDS-1:0] r_mask;
    logic [7:0]          r_int;
    logic                r_dout;
    logic                r_busy;
    logic                r_frame_start;

    logic                w_cell_end;
    logic                w_last_cell;
    logic                w_bit_val;
    logic [CW-1:0]       w_high_last;
    logic                w_dout_d;
    logic                w_busy_d;
    logic                w_frame_start_d;

    assign w_cell_end  = (r_cell_cnt == c_CELL_LAST);
    assign w_last_cell = (r_bit_idx == c_BIT_LAST) && (r_led_idx == c_LED_LAST);

    // Bit currently on the wire, taken straight from the snapshot.
    // bit_idx[4:3] selects the channel (0=G, 1=R, 2=B); CH_EN is packed {G,R,B}
    // so channel ch lives at CH_EN[2-ch]. bit_idx[2:0] walks the byte MSB first.
    assign w_bit_val = r_mask[r_led_idx]
                     & CH_EN[2'd2 - r_bit_idx[4:3]]
                     & r_int[3'd7 - r_bit_idx[2:0]];

    assign w_high_last = w_bit_val ? c_T1H_LAST : c_T0H_LAST;

    // ------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state       <= c_ST_GAP;
            r_dout        <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_dout        <= w_dout_d;
            r_busy        <= w_busy_d;
            r_frame_start <= w_frame_start_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_ST_GAP: begin
                if ((r_gap_cnt == c_GAP_LAST) && bus.enable) begin
                    w_state_nx = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_state_nx = c_ST_SEND;
            end
            c_ST_SEND: begin
                if (w_cell_end && w_last_cell) begin
                    w_state_nx = c_ST_GAP;
                end
            end
            default: begin
                w_state_nx = c_ST_GAP;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: computes the value each output takes in the next cycle
    // so the registered outputs line up with the state they describe.
    // Every cell starts high; it drops after the high time of the bit.
    // ------------------------------------------------------------------
    always_comb begin
        w_dout_d        = 1'b0;
        w_busy_d        = (w_state_nx == c_ST_SEND);
        w_frame_start_d = (w_state_nx == c_ST_LOAD);
        if (w_state_nx == c_ST_SEND) begin
            if ((r_state != c_ST_SEND) || w_cell_end) begin
                w_dout_d = 1'b1;
            end else if (r_cell_cnt == w_high_last) begin
                w_dout_d = 1'b0;
            end else begin
                w_dout_d = r_dout;
            end
        end
    end

    // ------------------------------------------------------------------
    // Gap / cell / bit / LED counters and input snapshot
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_gap_cnt  <= '0;
            r_cell_cnt <= '0;
            r_bit_idx  <= '0;
            r_led_idx  <= '0;
            r_mask     <= '0;
            r_int      <= '0;
        end else begin
            // Gap counter is held at zero outside GAP, so every gap is a full
            // T_RESET cycles; it saturates once the gap is complete.
            if (r_state == c_ST_GAP) begin
                if (r_gap_cnt != c_GAP_LAST) begin
                    r_gap_cnt <= r_gap_cnt + GW'(1);
                end
            end else begin
                r_gap_cnt <= '0;
            end

            if (r_state == c_ST_LOAD) begin
                r_mask     <= bus.led_mask;
                r_int      <= bus.intensity;
                r_cell_cnt <= '0;
                r_bit_idx  <= '0;
                r_led_idx  <= '0;
            end else if (r_state == c_ST_SEND) begin
                if (w_cell_end) begin
                    r_cell_cnt <= '0;
                    if (r_bit_idx == c_BIT_LAST) begin
                        r_bit_idx <= '0;
                        if (r_led_idx == c_LED_LAST) begin
                            r_led_idx <= '0;
                        end else begin
                            r_led_idx <= r_led_idx + LW'(1);
                        end
                    end else begin
                        r_bit_idx <= r_bit_idx + 5'd1;
                    end
                end else begin
                    r_cell_cnt <= r_cell_cnt + CW'(1);
                end
            end
        end
    end

    assign bus.dout        = r_dout;
    assign bus.busy        = r_busy;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ws2812b_driver
//  Purpose  : Directed testbench for ws2812b_driver. DUT A uses the default
//             timing and all channels; DUT B uses short timing with only the
//             R channel enabled. Frames are decoded cell by cell from dout.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812b_driver;

    logic clk;
    logic res_a;
    logic res_b;
    logic sel;

    int vectors;
    int errors;

    logic [23:0] dec_word [12];

    ws2812b_driver_if #(.NUM_LEDS(12)) bus_a ();
    ws2812b_driver_if #(.NUM_LEDS(12)) bus_b ();

    ws2812b_driver #(
        .NUM_LEDS(12), .T_BIT(50), .T0H(16), .T1H(32), .T_RESET(2400), .CH_EN(3'b111)
    ) u_dut_a (
        .clk (clk),
        .res (res_a),
        .bus (bus_a)
    );

    ws2812b_driver #(
        .NUM_LEDS(12), .T_BIT(10), .T0H(3), .T1H(6), .T_RESET(100), .CH_EN(3'b010)
    ) u_dut_b (
        .clk (clk),
        .res (res_b),
        .bus (bus_b)
    );

    wire mon_dout = sel ? bus_b.dout        : bus_a.dout;
    wire mon_busy = sel ? bus_b.busy        : bus_a.busy;
    wire mon_fs   = sel ? bus_b.frame_start : bus_a.frame_start;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] exp_word(input logic [11:0] mask, input logic [7:0] inten,
                                             input logic [2:0] chen, input int led);
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
        g = (mask[led] && chen[2]) ? inten : 8'h00;
        r = (mask[led] && chen[1]) ? inten : 8'h00;
        b = (mask[led] && chen[0]) ? inten : 8'h00;
        return {g, r, b};
    endfunction

    // Counts negedges until frame_start; the line must stay idle meanwhile.
    task automatic wait_frame_start(input int limit, input int exp_n, input string name);
        int n;
        int idle_bad;
        bit seen;
        n = 0;
        idle_bad = 0;
        seen = 1'b0;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            if (mon_fs === 1'b1) begin
                seen = 1'b1;
                if (mon_dout !== 1'b0 || mon_busy !== 1'b0) idle_bad++;
            end else if (mon_dout !== 1'b0 || mon_busy !== 1'b0) begin
                idle_bad++;
            end
        end
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: frame_start not seen within %0d cycles, required at cycle %0d", name, limit, exp_n);
        end else if (n != exp_n) begin
            errors++;
            $display("FAIL %s: frame_start at cycle %0d, required %0d", name, n, exp_n);
        end
        vectors++;
        if (idle_bad != 0) begin
            errors++;
            $display("FAIL %s_idle: dout/busy high in %0d gap/load cycles, required 0", name, idle_bad);
        end
    endtask

    // Called in the LOAD cycle; decodes all 288 cells into dec_word.
    task automatic decode_frame(input int tbit, input int t0h, input int t1h, input string name);
        int busy_cnt;
        busy_cnt = 0;
        for (int led = 0; led < 12; led++) begin
            logic [23:0] w;
            w = '0;
            for (int b = 0; b < 24; b++) begin
                int hi;
                bit fell;
                bit shape_ok;
                hi = 0;
                fell = 1'b0;
                shape_ok = 1'b1;
                for (int c = 0; c < tbit; c++) begin
                    @(negedge clk);
                    if (mon_busy === 1'b1) busy_cnt++;
                    if (mon_dout === 1'b1) begin
                        if (fell) shape_ok = 1'b0;
                        else hi++;
                    end else begin
                        fell = 1'b1;
                    end
                end
                vectors++;
                if (!shape_ok || (hi != t0h && hi != t1h)) begin
                    errors++;
                    $display("FAIL %s_cell led %0d bit %0d: leading high %0d cycles (single pulse=%0d), required %0d or %0d",
                             name, led, b, hi, shape_ok, t0h, t1h);
                end
                w = {w[22:0], (hi == t1h)};
            end
            dec_word[led] = w;
        end
        @(negedge clk);
        vectors++;
        if (mon_busy !== 1'b0 || mon_dout !== 1'b0) begin
            errors++;
            $display("FAIL %s_end: busy=%b dout=%b after last cell, required 0 0", name, mon_busy, mon_dout);
        end
        vectors++;
        if (busy_cnt != 12 * 24 * tbit) begin
            errors++;
            $display("FAIL %s_busy_len: busy high %0d cycles, required %0d", name, busy_cnt, 12 * 24 * tbit);
        end
    endtask

    task automatic check_words(input logic [11:0] mask, input logic [7:0] inten,
                               input logic [2:0] chen, input string name);
        logic [23:0] e;
        for (int i = 0; i < 12; i++) begin
            e = exp_word(mask, inten, chen, i);
            vectors++;
            if (dec_word[i] !== e) begin
                errors++;
                $display("FAIL %s led %0d: decoded %06h, required %06h", name, i, dec_word[i], e);
            end
        end
    endtask

    task automatic test_reset();
        res_a = 1'b1;
        res_b = 1'b1;
        bus_a.enable    = 1'b1;
        bus_a.led_mask  = 12'hFFF;
        bus_a.intensity = 8'hFF;
        bus_b.enable    = 1'b1;
        bus_b.led_mask  = 12'h800;
        bus_b.intensity = 8'h01;
        repeat (4) @(negedge clk);
        vectors++;
        if (bus_a.dout !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: dout/busy/fs=%b%b%b, required 000", bus_a.dout, bus_a.busy, bus_a.frame_start);
        end
        vectors++;
        if (bus_b.dout !== 1'b0 || bus_b.busy !== 1'b0 || bus_b.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: dout/busy/fs=%b%b%b, required 000", bus_b.dout, bus_b.busy, bus_b.frame_start);
        end
    endtask

    task automatic test_frame();
        sel = 1'b0;
        bus_a.led_mask  = 12'h001;
        bus_a.intensity = 8'h20;
        @(negedge clk);
        res_a = 1'b0;
        wait_frame_start(3000, 2400, "first_load");
        decode_frame(50, 16, 32, "frame1");
        vectors++;
        if (dec_word[0] !== 24'h202020) begin
            errors++;
            $display("FAIL frame1_led0: decoded %06h, required 202020", dec_word[0]);
        end
        check_words(12'h001, 8'h20, 3'b111, "frame1_words");
    endtask

    // Inputs change mid-SEND; enable drops mid-SEND of the following frame.
    task automatic test_in_flight();
        int fs_seen;
        sel = 1'b0;
        bus_a.led_mask  = 12'h0A5;
        bus_a.intensity = 8'h7F;
        wait_frame_start(3000, 2400, "gap_after_frame1");
        fork
            begin
                repeat (5000) @(negedge clk);
                bus_a.led_mask  = 12'hFFF;
                bus_a.intensity = 8'h03;
            end
            decode_frame(50, 16, 32, "frame2");
        join
        check_words(12'h0A5, 8'h7F, 3'b111, "frame2_words");
        wait_frame_start(3000, 2400, "gap_after_frame2");
        fork
            begin
                repeat (3000) @(negedge clk);
                bus_a.enable = 1'b0;
            end
            decode_frame(50, 16, 32, "frame3");
        join
        check_words(12'hFFF, 8'h03, 3'b111, "frame3_words");
        fs_seen = 0;
        repeat (3000) begin
            @(negedge clk);
            if (bus_a.frame_start !== 1'b0 || bus_a.dout !== 1'b0) fs_seen++;
        end
        vectors++;
        if (fs_seen != 0) begin
            errors++;
            $display("FAIL enable_blocks_load: %0d active cycles with enable=0, required 0", fs_seen);
        end
    endtask

    task automatic test_ch_en();
        sel = 1'b1;
        @(negedge clk);
        res_b = 1'b0;
        wait_frame_start(500, 100, "b_first_load");
        decode_frame(10, 3, 6, "frame_b");
        vectors++;
        if (dec_word[11] !== 24'h000100) begin
            errors++;
            $display("FAIL chen_led11: decoded %06h, required 000100", dec_word[11]);
        end
        check_words(12'h800, 8'h01, 3'b010, "frame_b_words");
        sel = 1'b0;
    endtask

    task automatic test_enable_low_and_abort();
        int bad;
        int hi;
        sel = 1'b0;
        @(negedge clk);
        res_a = 1'b1;
        bus_a.enable    = 1'b0;
        bus_a.led_mask  = 12'h001;
        bus_a.intensity = 8'hFF;
        @(negedge clk);
        res_a = 1'b0;
        bad = 0;
        repeat (10000) begin
            @(negedge clk);
            if (bus_a.dout !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.frame_start !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL enable_low_idle: %0d active cycles, required 0", bad);
        end
        bus_a.enable = 1'b1;
        wait_frame_start(10, 1, "load_after_enable");
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_a.dout === 1'b1 && bus_a.busy === 1'b1) hi++;
        end
        vectors++;
        if (hi != 10) begin
            errors++;
            $display("FAIL first_cell_high: dout&busy high %0d of 10 cycles, required 10", hi);
        end
        // Reset lands mid-cycle inside the high phase of a '1' cell.
        #2;
        res_a = 1'b1;
        #1;
        vectors++;
        if (bus_a.dout !== 1'b0 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_immediate: dout=%b busy=%b, required 0 0", bus_a.dout, bus_a.busy);
        end
        @(negedge clk);
        res_a = 1'b0;
        wait_frame_start(3000, 2400, "gap_after_abort");
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        sel     = 1'b0;
        test_reset();
        test_frame();
        test_in_flight();
        test_ch_en();
        test_enable_low_and_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
